// File: rtl/mant_div_seq_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_pkg: shared constants and types for the FP divide mantissa path.
//   MANT_W  : mantissa width including the hidden bit.
//   CNT_W   : width of the quotient-bit counter.
//   state_t : divider sequencer states.
// -----------------------------------------------------------------------------
package fp_div_pkg;

  localparam int MANT_W = 24;
  localparam int CNT_W  = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage : fp_div_pkg

// File: rtl/mant_div_seq_qbit_step.sv
// -----------------------------------------------------------------------------
// qbit_step: one restoring-division step (combinational).
//   r_i      [SIZE:0]   current partial remainder
//   d_i      [SIZE-1:0] divisor mantissa
//   bit_o               quotient bit, (r_i >= d_i)
//   r_next_o [SIZE:0]   (bit ? r - d : r) << 1, truncated to SIZE+1 bits
// -----------------------------------------------------------------------------
module qbit_step
  import fp_div_pkg::*;
#(
  parameter int SIZE = MANT_W
) (
  input  logic [SIZE:0]   r_i,
  input  logic [SIZE-1:0] d_i,
  output logic            bit_o,
  output logic [SIZE:0]   r_next_o
);

  logic [SIZE:0] d_ext;
  logic [SIZE:0] r_sel;

  assign d_ext = {1'b0, d_i};
  assign bit_o = (r_i >= d_ext);
  assign r_sel = bit_o ? (r_i - d_ext) : r_i;
  // After a step the remainder is below d < 2^SIZE, so dropping the MSB
  // on the shift never loses information.
  assign r_next_o = {r_sel[SIZE-1:0], 1'b0};

endmodule : qbit_step

// File: rtl/mant_div_seq.sv
// -----------------------------------------------------------------------------
// mant_div_seq: sequential restoring divider for normalized mantissas.
// Emits one quotient bit per clock, MSB (2^0 weight) first, to a downstream
// serial quotient register.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               divide request, honoured only in IDLE
//   dividend, divisor   operand mantissas, captured on acceptance
//   busy                high from acceptance through the last emitted bit
//   q_ld                one-cycle "clear quotient register" pulse
//   q_sld, q_sin        serial quotient bit strobe and data
//   done                one-cycle completion pulse
//   rem                 final partial remainder, held until next acceptance
//   div_by_zero         pulses with done when the divisor is zero
//   sticky              remainder-nonzero flag
//
// Build option: define MANT_DIV_STICKY_EN to generate the sticky flag;
// otherwise sticky is tied low.
// -----------------------------------------------------------------------------
module mant_div_seq
  import fp_div_pkg::*;
#(
  parameter int SIZE = MANT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            q_ld,
  output logic            q_sld,
  output logic            q_sin,
  output logic            done,
  output logic [SIZE:0]   rem,
  output logic            div_by_zero,
  output logic            sticky
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SIZE:0]     r_q;
  logic [SIZE-1:0]   d_q;
  logic              busy_q, q_ld_q, q_sld_q, q_sin_q, done_q, dbz_q;
  logic [SIZE:0]     rem_q;

  logic              bit_d;
  logic [SIZE:0]     r_d;

  qbit_step #(.SIZE(SIZE)) u_step (
    .r_i      (r_q),
    .d_i      (d_q),
    .bit_o    (bit_d),
    .r_next_o (r_d)
  );

`ifdef MANT_DIV_STICKY_EN
  logic sticky_q;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      q_ld_q  <= 1'b0;
      q_sld_q <= 1'b0;
      q_sin_q <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      rem_q   <= '0;
`ifdef MANT_DIV_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low each cycle.
      q_ld_q  <= 1'b0;
      q_sld_q <= 1'b0;
      q_sin_q <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // done_q is high only in the cycle after FIN; blocking acceptance
          // then keeps a start coincident with done from being taken.
          if (start && !done_q) begin
            r_q   <= {1'b0, dividend};
            d_q   <= divisor;
            cnt_q <= '0;
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= 1'b0;
`endif
            if (divisor == '0) begin
              state_q <= FIN;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              q_ld_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          q_sin_q <= bit_d;
          q_sld_q <= 1'b1;
          r_q     <= r_d;
          if (cnt_q == LAST_CNT) state_q <= FIN;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          dbz_q   <= (d_q == '0);
          rem_q   <= r_q >> 1;
`ifdef MANT_DIV_STICKY_EN
          sticky_q <= |r_q[SIZE:1];
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign q_ld        = q_ld_q;
  assign q_sld       = q_sld_q;
  assign q_sin       = q_sin_q;
  assign done        = done_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
`ifdef MANT_DIV_STICKY_EN
  assign sticky      = sticky_q;
`else
  assign sticky      = 1'b0;
`endif

endmodule : mant_div_seq

// File: tb/tb_mant_div_seq.sv
// -----------------------------------------------------------------------------
// tb_mant_div_seq: scoreboard bench for mant_div_seq. Expected quotient and
// remainder come from integer division; a negedge monitor reassembles the
// serial quotient and compares on each done pulse.
// -----------------------------------------------------------------------------
module tb_mant_div_seq;

  localparam int SIZE = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] dividend, divisor;
  logic            busy, q_ld, q_sld, q_sin, done, div_by_zero, sticky;
  logic [SIZE:0]   rem;

  mant_div_seq #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .q_ld(q_ld), .q_sld(q_sld), .q_sin(q_sin), .done(done),
    .rem(rem), .div_by_zero(div_by_zero), .sticky(sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SIZE-1:0] q;
    logic [SIZE:0]   rem;
    bit              dbz;
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    exp_t e;
    logic [47:0] num, q48;
    e.acc_cyc = 0;
    if (b == '0) begin
      e.dbz = 1'b1; e.q = '0; e.rem = '0;
    end else begin
      num   = 48'(a) << (SIZE - 1);
      q48   = num / 48'(b);
      e.dbz = 1'b0;
      e.q   = q48[SIZE-1:0];
      e.rem = 25'(num - q48 * 48'(b));
    end
    return e;
  endfunction

  // Monitor: reassemble serial quotient and score on done.
  logic [SIZE-1:0] sh;
  int nbits, qld_cnt;
  bit busy_seen;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sh = '0; nbits = 0; qld_cnt = 0; busy_seen = 0;
    end else begin
      if (q_ld || q_sld) check("ld_sld_excl", 64'(q_ld & q_sld), 64'd0);
      if (busy) busy_seen = 1;
      if (q_ld) begin qld_cnt++; sh = '0; nbits = 0; end
      if (q_sld) begin sh = {sh[SIZE-2:0], q_sin}; nbits++; end
      if (done) begin
        if (sb.size() == 0) begin
          check("sb_empty_on_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 64'(cyc - e.acc_cyc), e.dbz ? 64'd1 : 64'(SIZE + 1));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          if (e.dbz) begin
            check("dbz_nbits", 64'(nbits), 64'd0);
            check("dbz_qld", 64'(qld_cnt), 64'd0);
            check("dbz_busy", 64'(busy_seen), 64'd0);
          end else begin
            check("nbits", 64'(nbits), 64'(SIZE));
            check("qld_cnt", 64'(qld_cnt), 64'd1);
            check("quotient", 64'(sh), 64'(e.q));
            check("rem", 64'(rem), 64'(e.rem));
`ifdef MANT_DIV_STICKY_EN
            check("sticky", 64'(sticky), 64'(e.rem != '0));
`else
            check("sticky", 64'(sticky), 64'd0);
`endif
          end
        end
        sh = '0; nbits = 0; qld_cnt = 0; busy_seen = 0;
      end
    end
  end

  // Drive one divide. repulse_at >= 0 re-pulses start mid-run; rst_at >= 0
  // resets mid-run; poke_done drives start during the done cycle.
  task automatic run_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input int repulse_at, input int rst_at, input bit poke_done);
    exp_t e;
    bit got_done;
    e = model(a, b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    dividend = 24'($urandom);
    divisor  = 24'($urandom);
    got_done = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == repulse_at) begin
        start = 1'b1; dividend = 24'hFFFFFF; divisor = 24'h900001;
      end else begin
        start = 1'b0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_qld_qsld_qsin", 64'({q_ld, q_sld, q_sin}), 64'd0);
        check("rst_done_dbz_sticky", 64'({done, div_by_zero, sticky}), 64'd0);
        check("rst_rem", 64'(rem), 64'd0);
        @(negedge clk);
        check("rst_no_qsld", 64'(q_sld), 64'd0);
        rst = 1'b0;
        sb.delete();
        return;
      end
      @(negedge clk);
      if (done) begin got_done = 1; break; end
    end
    start = 1'b0;
    if (!got_done) begin
      check("done_timeout", 64'd1, 64'd0);
      return;
    end
    if (poke_done) begin
      start = 1'b1; dividend = 24'hA00000; divisor = 24'h800000;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_busy", 64'(busy), 64'd0);
      check("start_in_done_qld", 64'(q_ld), 64'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pulses", 64'({q_ld, q_sld, q_sin, done, div_by_zero, sticky}), 64'd0);
    check("reset_rem", 64'(rem), 64'd0);
    rst = 1'b0;

    run_div(24'hC00000, 24'h800000, -1, -1, 1'b0);
    run_div(24'h800000, 24'hC00000, -1, -1, 1'b0);
    run_div(24'h800000, 24'h800000, -1, -1, 1'b1);
    run_div(24'hABCDEF, 24'h000000, -1, -1, 1'b0);
    run_div(24'hFFFFFF, 24'h800000, -1, -1, 1'b0);
    run_div(24'h800000, 24'hFFFFFF, -1, -1, 1'b0);
    run_div(24'hC00000, 24'h800000, 10, -1, 1'b0);
    run_div(24'h9A5A5A, 24'hD12345, -1, 12, 1'b0);
    run_div(24'h9A5A5A, 24'hD12345, -1, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_div(24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom), -1, -1, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mant_div_seq
